// File: rtl/sweep_monitor_pkg.sv
// Shared types and constants for the bounce-counter sweep monitor.
//   state_t  : monitor FSM state encoding
//   DIR_UP / DIR_DOWN : meaning of the upstream direction flag
package sweep_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear (count -> 0), highest synchronous priority
//   inc   : count up by one unless already at MAX_VAL
//   zero  : synchronous restart at 0 (priority over inc)
//   q     : current count
module sat_counter #(
  parameter int           W       = 8,
  parameter logic [W-1:0] MAX_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         zero,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || zero)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX_VAL))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/sweep_monitor.sv
// Checks the sample stream of an up/down bounce counter: every step must be
// +-1 in the current direction, or a turnaround at an end point. Reports
// turnarounds, counts completed sweeps, flags faults and indicates lock once
// LOCK_N consecutive legal steps were seen.
//   clk, reset (async active-low), clr (sync clear)
//   smp_valid, cnt_in[W], dir_in      : upstream sample
//   state_o, locked, turn_top, turn_bot, sweep_cnt[CW], err, err_cnt[CW],
//   last_cnt[W]                       : registered status outputs
module sweep_monitor
  import sweep_monitor_pkg::*;
#(
  parameter int W      = 4,
  parameter int CW     = 8,
  parameter int LOCK_N = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          smp_valid,
  input  logic [W-1:0]  cnt_in,
  input  logic          dir_in,
  output logic [1:0]    state_o,
  output logic          locked,
  output logic          turn_top,
  output logic          turn_bot,
  output logic [CW-1:0] sweep_cnt,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [W-1:0]  last_cnt
);

  localparam logic [W-1:0]  ONE     = W'(1);
  localparam logic [W-1:0]  MINUS1  = '1;
  localparam logic [W-1:0]  MAXV    = '1;
  localparam logic [CW-1:0] LOCK_CW = CW'(LOCK_N);

  state_t        state_d, state_q;
  logic [W-1:0]  last_cnt_d, last_cnt_q;
  logic          locked_d, locked_q;
  logic          turn_top_d, turn_top_q;
  logic          turn_bot_d, turn_bot_q;
  logic          err_d, err_q;
  logic [CW-1:0] run_cnt, run_next;
  logic [W-1:0]  delta;
  logic          legal, illegal, seed, bot_evt;

  // Modulo-2^W difference, so MAX->0 shows as +1 and 0->MAX as -1.
  assign delta    = cnt_in - last_cnt_q;
  assign run_next = (run_cnt >= LOCK_CW) ? LOCK_CW : run_cnt + 1'b1;

  always_comb begin
    state_d    = state_q;
    last_cnt_d = last_cnt_q;
    locked_d   = locked_q;
    turn_top_d = 1'b0;
    turn_bot_d = 1'b0;
    err_d      = err_q;
    legal      = 1'b0;
    illegal    = 1'b0;
    seed       = 1'b0;
    bot_evt    = 1'b0;
    if (smp_valid) begin
      unique case (state_q)
        IDLE, FAULT: begin
          seed       = 1'b1;
          last_cnt_d = cnt_in;
          state_d    = (dir_in == DIR_DOWN) ? DOWN : UP;
        end
        UP: begin
          if (delta == ONE && last_cnt_q != MAXV) begin
            legal = 1'b1;
          end else if (last_cnt_q == MAXV && delta == MINUS1) begin
            legal      = 1'b1;
            turn_top_d = 1'b1;
            state_d    = DOWN;
          end else begin
            illegal = 1'b1;
          end
        end
        DOWN: begin
          if (delta == MINUS1 && last_cnt_q != '0) begin
            legal = 1'b1;
          end else if (last_cnt_q == '0 && delta == ONE) begin
            legal      = 1'b1;
            turn_bot_d = 1'b1;
            bot_evt    = 1'b1;
            state_d    = UP;
          end else begin
            illegal = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (legal) begin
        last_cnt_d = cnt_in;
        locked_d   = (run_next == LOCK_CW);
      end
      if (illegal) begin
        state_d    = FAULT;
        err_d      = 1'b1;
        locked_d   = 1'b0;
        last_cnt_d = cnt_in;
      end
    end
    if (clr) begin
      state_d    = IDLE;
      last_cnt_d = '0;
      locked_d   = 1'b0;
      turn_top_d = 1'b0;
      turn_bot_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_cnt_q <= '0;
      locked_q   <= 1'b0;
      turn_top_q <= 1'b0;
      turn_bot_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cnt_q <= last_cnt_d;
      locked_q   <= locked_d;
      turn_top_q <= turn_top_d;
      turn_bot_q <= turn_bot_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CW)) u_sweep_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(bot_evt), .zero(1'b0), .q(sweep_cnt)
  );

  sat_counter #(.W(CW)) u_err_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(illegal), .zero(1'b0), .q(err_cnt)
  );

  // Consecutive legal steps, parked at LOCK_N once lock is reached.
  sat_counter #(.W(CW), .MAX_VAL(LOCK_CW)) u_run_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(legal), .zero(illegal | seed), .q(run_cnt)
  );

  assign state_o  = state_q;
  assign locked   = locked_q;
  assign turn_top = turn_top_q;
  assign turn_bot = turn_bot_q;
  assign err      = err_q;
  assign last_cnt = last_cnt_q;

endmodule

// File: tb/tb_sweep_monitor.sv
// Directed bench for sweep_monitor: a default-parameter instance plus a
// CW=2 / LOCK_N=2 instance driven by the same stimulus.
module tb_sweep_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       smp_valid = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       dir_in = 1'b0;

  logic [1:0] state_o;
  logic       locked, turn_top, turn_bot, err;
  logic [7:0] sweep_cnt, err_cnt;
  logic [3:0] last_cnt;

  logic [1:0] state2;
  logic       locked2, ttop2, tbot2, err2;
  logic [1:0] sweep2, errc2;
  logic [3:0] last2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sweep_monitor #(.W(4), .CW(8), .LOCK_N(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .smp_valid(smp_valid),
    .cnt_in(cnt_in), .dir_in(dir_in), .state_o(state_o), .locked(locked),
    .turn_top(turn_top), .turn_bot(turn_bot), .sweep_cnt(sweep_cnt),
    .err(err), .err_cnt(err_cnt), .last_cnt(last_cnt)
  );

  sweep_monitor #(.W(4), .CW(2), .LOCK_N(2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr), .smp_valid(smp_valid),
    .cnt_in(cnt_in), .dir_in(dir_in), .state_o(state2), .locked(locked2),
    .turn_top(ttop2), .turn_bot(tbot2), .sweep_cnt(sweep2),
    .err(err2), .err_cnt(errc2), .last_cnt(last2)
  );

  task automatic feed(input logic [3:0] v, input logic d);
    cnt_in = v; dir_in = d; smp_valid = 1'b1;
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; clr = 1'b0; smp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b want 0", locked); else passed++;
    total++; if ({turn_top, turn_bot} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {turn_top, turn_bot}); else passed++;
    total++; if (sweep_cnt !== 8'd0) $display("FAIL rst_sweep: got %0d want 0", sweep_cnt); else passed++;
    total++; if ({err, err_cnt} !== 9'd0) $display("FAIL rst_err: got %0b/%0d want 0/0", err, err_cnt); else passed++;
    total++; if (last_cnt !== 4'd0) $display("FAIL rst_last: got %0d want 0", last_cnt); else passed++;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_sweep();
    apply_reset();
    for (int v = 0; v <= 15; v++) begin
      feed(4'(v), 1'b0);
      if (v == 3) begin
        total++; if (locked !== 1'b0) $display("FAIL sweep_lock3: got %0b want 0", locked); else passed++;
      end
      if (v == 4) begin
        total++; if (locked !== 1'b1) $display("FAIL sweep_lock4: got %0b want 1", locked); else passed++;
      end
    end
    total++; if (state_o !== 2'd1 || turn_top !== 1'b0) $display("FAIL sweep_at15: got st=%0d tt=%0b want 1/0", state_o, turn_top); else passed++;
    for (int v = 14; v >= 0; v--) begin
      feed(4'(v), 1'b1);
      if (v == 14) begin
        total++; if (turn_top !== 1'b1 || state_o !== 2'd2) $display("FAIL sweep_turn_top: got tt=%0b st=%0d want 1/2", turn_top, state_o); else passed++;
      end
      if (v == 13) begin
        total++; if (turn_top !== 1'b0) $display("FAIL sweep_tt_drop: got %0b want 0", turn_top); else passed++;
      end
    end
    total++; if (sweep_cnt !== 8'd0 || turn_bot !== 1'b0) $display("FAIL sweep_at0: got sc=%0d tb=%0b want 0/0", sweep_cnt, turn_bot); else passed++;
    feed(4'd1, 1'b0);
    total++; if (turn_bot !== 1'b1) $display("FAIL sweep_turn_bot: got %0b want 1", turn_bot); else passed++;
    total++; if (sweep_cnt !== 8'd1) $display("FAIL sweep_cnt1: got %0d want 1", sweep_cnt); else passed++;
    total++; if (err !== 1'b0 || state_o !== 2'd1 || last_cnt !== 4'd1) $display("FAIL sweep_end: got err=%0b st=%0d last=%0d want 0/1/1", err, state_o, last_cnt); else passed++;
  endtask

  task automatic test_fault();
    apply_reset();
    for (int v = 0; v <= 3; v++) feed(4'(v), 1'b0);
    feed(4'd5, 1'b0);
    total++; if (state_o !== 2'd3) $display("FAIL jump_state: got %0d want 3", state_o); else passed++;
    total++; if (err !== 1'b1 || err_cnt !== 8'd1) $display("FAIL jump_err: got %0b/%0d want 1/1", err, err_cnt); else passed++;
    total++; if (locked !== 1'b0 || last_cnt !== 4'd5) $display("FAIL jump_lock_last: got %0b/%0d want 0/5", locked, last_cnt); else passed++;
    feed(4'd6, 1'b0);
    total++; if (state_o !== 2'd1 || err_cnt !== 8'd1) $display("FAIL reseed: got st=%0d ec=%0d want 1/1", state_o, err_cnt); else passed++;
    for (int v = 7; v <= 9; v++) feed(4'(v), 1'b0);
    total++; if (locked !== 1'b0) $display("FAIL relock9: got %0b want 0", locked); else passed++;
    feed(4'd10, 1'b0);
    total++; if (locked !== 1'b1 || err !== 1'b1) $display("FAIL relock10: got lk=%0b err=%0b want 1/1", locked, err); else passed++;
  endtask

  task automatic test_wraps();
    apply_reset();
    for (int v = 12; v <= 15; v++) feed(4'(v), 1'b0);
    feed(4'd0, 1'b0);
    total++; if (state_o !== 2'd3 || err_cnt !== 8'd1) $display("FAIL wrap_top: got st=%0d ec=%0d want 3/1", state_o, err_cnt); else passed++;
    feed(4'd2, 1'b1);
    total++; if (state_o !== 2'd2) $display("FAIL seed_down: got %0d want 2", state_o); else passed++;
    feed(4'd1, 1'b1);
    feed(4'd0, 1'b1);
    feed(4'd15, 1'b1);
    total++; if (state_o !== 2'd3 || err_cnt !== 8'd2) $display("FAIL wrap_bot: got st=%0d ec=%0d want 3/2", state_o, err_cnt); else passed++;
    feed(4'd7, 1'b0);
    feed(4'd7, 1'b0);
    total++; if (state_o !== 2'd3 || err_cnt !== 8'd3 || last_cnt !== 4'd7) $display("FAIL repeat: got st=%0d ec=%0d last=%0d want 3/3/7", state_o, err_cnt, last_cnt); else passed++;
  endtask

  task automatic test_hold_clr();
    apply_reset();
    for (int v = 0; v <= 15; v++) feed(4'(v), 1'b0);
    feed(4'd14, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (turn_top !== 1'b0 || state_o !== 2'd2 || last_cnt !== 4'd14 || locked !== 1'b1 || err !== 1'b0)
        $display("FAIL hold_%0d: got tt=%0b st=%0d last=%0d lk=%0b err=%0b want 0/2/14/1/0", i, turn_top, state_o, last_cnt, locked, err);
      else passed++;
    end
    feed(4'd13, 1'b1);
    total++; if (state_o !== 2'd2 || last_cnt !== 4'd13 || err !== 1'b0) $display("FAIL hold_resume: got st=%0d last=%0d err=%0b want 2/13/0", state_o, last_cnt, err); else passed++;
    clr = 1'b1;
    feed(4'd12, 1'b1);
    clr = 1'b0;
    total++; if (state_o !== 2'd0 || last_cnt !== 4'd0 || locked !== 1'b0) $display("FAIL clr_state: got st=%0d last=%0d lk=%0b want 0/0/0", state_o, last_cnt, locked); else passed++;
    total++; if (sweep_cnt !== 8'd0 || err_cnt !== 8'd0 || err !== 1'b0) $display("FAIL clr_cnts: got sc=%0d ec=%0d err=%0b want 0/0/0", sweep_cnt, err_cnt, err); else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    feed(4'd0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      for (int v = (s == 0) ? 1 : 2; v <= 15; v++) feed(4'(v), 1'b0);
      for (int v = 14; v >= 0; v--) feed(4'(v), 1'b1);
      feed(4'd1, 1'b0);
    end
    feed(4'd2, 1'b0);
    total++; if (sweep_cnt !== 8'd2 || locked !== 1'b1) $display("FAIL pre_async: got sc=%0d lk=%0b want 2/1", sweep_cnt, locked); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (sweep_cnt !== 8'd0 || locked !== 1'b0 || state_o !== 2'd0 || last_cnt !== 4'd0) $display("FAIL async_clear: got sc=%0d lk=%0b st=%0d last=%0d want 0/0/0/0", sweep_cnt, locked, state_o, last_cnt); else passed++;
    #1 reset = 1'b1;
    feed(4'd0, 1'b0);
    total++; if (state_o !== 2'd1 || last_cnt !== 4'd0) $display("FAIL async_seed: got st=%0d last=%0d want 1/0", state_o, last_cnt); else passed++;
    feed(4'd1, 1'b0);
    total++; if (state_o !== 2'd1 || last_cnt !== 4'd1 || err !== 1'b0) $display("FAIL async_resume: got st=%0d last=%0d err=%0b want 1/1/0", state_o, last_cnt, err); else passed++;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_sw [5];
    exp_sw[0] = 2'd1; exp_sw[1] = 2'd2; exp_sw[2] = 2'd3; exp_sw[3] = 2'd3; exp_sw[4] = 2'd3;
    apply_reset();
    feed(4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int v = (k == 0) ? 1 : 2; v <= 15; v++) feed(4'(v), 1'b0);
      for (int v = 14; v >= 0; v--) feed(4'(v), 1'b1);
      feed(4'd1, 1'b0);
      total++; if (sweep2 !== exp_sw[k]) $display("FAIL sat_sweep_%0d: got %0d want %0d", k, sweep2, exp_sw[k]); else passed++;
    end
    total++; if (err2 !== 1'b0 || errc2 !== 2'd0) $display("FAIL sat_clean: got %0b/%0d want 0/0", err2, errc2); else passed++;
    feed(4'd5, 1'b0);
    total++; if (errc2 !== 2'd1) $display("FAIL sat_err_1: got %0d want 1", errc2); else passed++;
    for (int i = 2; i <= 5; i++) begin
      feed(4'd3, 1'b0);
      feed(4'd3, 1'b0);
      total++; if (errc2 !== ((i > 3) ? 2'd3 : 2'(i))) $display("FAIL sat_err_%0d: got %0d want %0d", i, errc2, (i > 3) ? 3 : i); else passed++;
    end
    total++; if (err_cnt !== 8'd5) $display("FAIL wide_err_cnt: got %0d want 5", err_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_fault();
    test_wraps();
    test_hold_clr();
    test_async_reset();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sweep_monitor.md
Name: sweep_monitor

Overview:
- Downstream consumer of the 4-bit bounce (up/down triangle) counter.
- Samples the counter value and direction flag, and checks that every step is a legal ±1 move or a turnaround at an end point.
- Reports turnaround events and counts completed sweeps.
- Flags sequence faults, and raises a lock indication once the counter has tracked cleanly for a programmable number of steps.

Parameters:
- W, 4, counter value width; MAX = 2^W-1
- CW, 8, width of sweep and error counters (saturating)
- LOCK_N, 4, consecutive legal steps required to assert locked (1..2^CW-1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear, same effect as reset; priority over smp_valid
- smp_valid  in  1  cnt_in/dir_in valid this cycle
- cnt_in  in  W  counter value from upstream
- dir_in  in  1  upstream direction flag; 0 = counting up, 1 = counting down
- state_o  out  2  current FSM state
- locked  out  1  tracking established
- turn_top  out  1  one-cycle pulse: MAX→MAX-1 turnaround accepted
- turn_bot  out  1  one-cycle pulse: 0→1 turnaround accepted
- sweep_cnt  out  CW  completed full sweeps (incremented on turn_bot), saturating
- err  out  1  sticky fault flag
- err_cnt  out  CW  illegal steps seen, saturating
- last_cnt  out  W  last accepted sample

Behaviour:
- All outputs registered. Reset (reset=0, asynchronous) and clr=1 (at the clock edge) force:
  - state IDLE, locked 0, turn_top/turn_bot 0, sweep_cnt 0, err 0, err_cnt 0, last_cnt 0, run counter 0.
- A sample is accepted at a rising edge with smp_valid=1 and clr=0. With smp_valid=0 all state holds and pulses drop to 0.
- Latency: every effect of an accepted sample is visible on the outputs after the same edge (one-cycle registered).
- delta = cnt_in - last_cnt, modulo 2^W.
- FSM states: IDLE, UP, DOWN, FAULT.
- IDLE or FAULT + sample (seed):
  - last_cnt <= cnt_in; state <= UP if dir_in=0, else DOWN.
  - run counter <= 0; no error, no pulse.
  - dir_in is used only when seeding.
- UP + sample:
  - delta=+1 and last_cnt≠MAX: legal, stay UP.
  - last_cnt=MAX and delta=-1: legal, turn_top=1, go DOWN.
  - Anything else is illegal, including a repeated value, a jump, or the wrap MAX→0.
- DOWN + sample:
  - delta=-1 and last_cnt≠0: legal, stay DOWN.
  - last_cnt=0 and delta=+1: legal, turn_bot=1, sweep_cnt+1 (saturating), go UP.
  - Anything else is illegal, including the wrap 0→MAX.
- Legal step: last_cnt <= cnt_in; run counter +1, saturating at LOCK_N; locked <= (run counter reaches LOCK_N).
- Illegal step:
  - state <= FAULT; err <= 1 (sticky until reset/clr); err_cnt+1 (saturating).
  - locked <= 0; run counter <= 0; last_cnt <= cnt_in.
  - No pulse.
- Saturating counters hold at all-ones and never wrap.
- Reset asserted mid-sweep clears outputs immediately, without waiting for a clock edge.

Decomposition:
- Package sweep_monitor_pkg: state typedef enum logic [1:0] {IDLE=0, UP=1, DOWN=2, FAULT=3}; constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module sat_counter, parameterised by width. Inputs: clk, reset, clr, inc, zero. Instantiated for sweep_cnt, err_cnt and the lock run counter.

Test Plan:
- Reset, then valid every cycle with 0..15,14..0,1 (dir per upstream) → locked=1 after sample 4; turn_top=1 the cycle after 14 is accepted; turn_bot=1 and sweep_cnt=1 after the final 1; err=0; state_o=UP.
- In UP after 3, feed 5 → state FAULT, err=1, err_cnt=1, locked=0. Then feed 6 with dir 0 → reseed UP; locked returns after 7,8,9,10; err stays 1.
- In UP at 15, feed 0 → FAULT, err_cnt+1. In DOWN at 0, feed 15 → FAULT. Feed a repeated value 7,7 → FAULT.
- smp_valid low for 5 cycles mid-sweep → all outputs hold, pulses 0. clr=1 with smp_valid=1 → all outputs at reset values, sample ignored.
- Pull reset low between clock edges mid-sweep with sweep_cnt=2 → all outputs zero immediately. Release, then feed 0,1 → seeded, counting resumes.
- CW=2: run 5 full sweeps → sweep_cnt reads 1,2,3,3,3. Force 5 faults → err_cnt saturates at 3.
